// File: rtl/pcma_coe_loader.sv
// pcma_coe_loader: holds an EQ_LEN-tap coefficient buffer, streams it to the
// equalizer as one load_coe pulse per tap, issues presets and gates adaptation.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   cfg_wr, cfg_addr, cfg_data coefficient buffer write port (IDLE only)
//   cmd_load, cmd_preset       sequence commands (preset wins when both)
//   teach_req                  host adaptation enable
//   load_coe, o_init_coe       per-tap load pulse and its coefficient
//   preset_coe                 one-cycle equalizer preset pulse
//   teach_en                   adaptation enable, low while a sequence runs
//   busy, done, cmd_err        sequence status and rejected-request pulse
module pcma_coe_loader #(
    parameter int COE_WIDTH     = 16,
    parameter int INV_COE_WIDTH = 8,
    parameter int EQ_LEN        = 17,
    parameter int GAP           = 2,
    parameter int SETTLE_LEN    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_wr,
    input  logic [5:0]                         cfg_addr,
    input  logic [COE_WIDTH+INV_COE_WIDTH-1:0] cfg_data,
    input  logic                               cmd_load,
    input  logic                               cmd_preset,
    input  logic                               teach_req,
    output logic                               load_coe,
    output logic [COE_WIDTH+INV_COE_WIDTH-1:0] o_init_coe,
    output logic                               preset_coe,
    output logic                               teach_en,
    output logic                               busy,
    output logic                               done,
    output logic                               cmd_err
);

    localparam int FW = COE_WIDTH + INV_COE_WIDTH;
    localparam int AW = $clog2(EQ_LEN);

    localparam logic [AW-1:0] K_LAST  = AW'(EQ_LEN - 1);
    localparam logic [5:0]    LEN6    = 6'(EQ_LEN);
    localparam logic [9:0]    S_END   = 10'(SETTLE_LEN);
    localparam logic [9:0]    G_END   = 10'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [FW-1:0] PRE_VAL = FW'((1 << (COE_WIDTH - 3)) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESET,
        S_LOAD,
        S_GAP,
        S_SETTLE
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   k, k_n;
    logic [9:0]      cnt, cnt_n;
    logic [FW-1:0]   coe_buf [EQ_LEN];

    logic            idle;
    logic            addr_ok;
    logic            load_n;
    logic [FW-1:0]   coe_n;
    logic            preset_n;
    logic            teach_n;
    logic            busy_n;
    logic            done_n;
    logic            err_n;

    assign idle    = (state == S_IDLE);
    assign addr_ok = (cfg_addr < LEN6);

    // Outputs are registered copies of what the next state implies, so each
    // output cycle lines up exactly with the state occupied in that cycle.
    always_comb begin
        state_n = state;
        k_n     = k;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (cmd_preset) begin
                    state_n = S_PRESET;
                end else if (cmd_load) begin
                    state_n = S_LOAD;
                    k_n     = '0;
                end
            end
            S_PRESET: begin
                state_n = S_SETTLE;
                cnt_n   = '0;
            end
            S_LOAD: begin
                if (k == K_LAST) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end else if (GAP == 0) begin
                    k_n = k + 1'b1;
                end else begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                end
            end
            S_GAP: begin
                if (cnt == G_END) begin
                    state_n = S_LOAD;
                    k_n     = k + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SETTLE: begin
                // SETTLE_LEN quiet cycles, then one more cycle carrying done
                if (cnt == S_END) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        load_n   = (state_n == S_LOAD);
        coe_n    = load_n ? coe_buf[k_n] : '0;
        preset_n = (state_n == S_PRESET);
        busy_n   = (state_n != S_IDLE);
        done_n   = (state_n == S_SETTLE) && (cnt_n == S_END);
        teach_n  = teach_req && (state_n == S_IDLE);
        err_n    = idle ? (cfg_wr && !addr_ok)
                        : (cfg_wr || cmd_load || cmd_preset);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= '0;
            cnt        <= '0;
            load_coe   <= 1'b0;
            o_init_coe <= '0;
            preset_coe <= 1'b0;
            teach_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
            for (int i = 0; i < EQ_LEN; i++) begin
                coe_buf[i] <= (i == EQ_LEN / 2) ? PRE_VAL : '0;
            end
        end else begin
            state      <= state_n;
            k          <= k_n;
            cnt        <= cnt_n;
            load_coe   <= load_n;
            o_init_coe <= coe_n;
            preset_coe <= preset_n;
            teach_en   <= teach_n;
            busy       <= busy_n;
            done       <= done_n;
            cmd_err    <= err_n;
            if (idle && cfg_wr && addr_ok) begin
                coe_buf[cfg_addr[AW-1:0]] <= cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_pcma_coe_loader.sv
// tb_pcma_coe_loader: directed and randomized checks of pcma_coe_loader
// against a cycle-timing reference model derived from the load/preset rules.
module tb_pcma_coe_loader;

    localparam int CW = 16;
    localparam int IW = 8;
    localparam int FW = CW + IW;
    localparam int L  = 17;
    localparam int G  = 2;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_wr;
    logic [5:0]    cfg_addr;
    logic [FW-1:0] cfg_data;
    logic          cmd_load;
    logic          cmd_preset;
    logic          teach_req;
    logic          load_coe;
    logic [FW-1:0] o_init_coe;
    logic          preset_coe;
    logic          teach_en;
    logic          busy;
    logic          done;
    logic          cmd_err;

    int nchk = 0;
    int nerr = 0;

    logic [FW-1:0] mbuf [L];

    pcma_coe_loader #(
        .COE_WIDTH(CW), .INV_COE_WIDTH(IW), .EQ_LEN(L),
        .GAP(G), .SETTLE_LEN(S)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cmd_load(cmd_load), .cmd_preset(cmd_preset),
        .teach_req(teach_req),
        .load_coe(load_coe), .o_init_coe(o_init_coe),
        .preset_coe(preset_coe), .teach_en(teach_en),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) mbuf[i] = '0;
        mbuf[L/2] = FW'((1 << (CW - 3)) - 1);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_in();
        cfg_wr     = 1'b0;
        cmd_load   = 1'b0;
        cmd_preset = 1'b0;
    endtask

    task automatic do_write(input int addr, input logic [FW-1:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = 6'(addr);
        cfg_data = d;
        step();
        cfg_wr = 1'b0;
        chk("wr_err", 32'(cmd_err), 32'(addr >= L));
        if (addr < L) mbuf[addr] = d;
    endtask

    // Start a command in the current (idle) cycle and check every following
    // cycle. err_at: cycle in which an illegal request is driven (0 = none).
    // abort_at: cycle in which reset is raised (0 = none).
    task automatic run_seq(input bit ld, input bit pr, input bit tr,
                           input int err_at, input int err_kind,
                           input int abort_at);
        int  d_cyc;
        int  last;
        int  kk;
        bit  le;
        logic [FW-1:0] ce;
        d_cyc = pr ? S + 2 : 1 + (L - 1) * (G + 1) + S + 1;
        last  = (abort_at > 0) ? abort_at + 1 : d_cyc + 2;
        teach_req  = tr;
        cmd_load   = ld;
        cmd_preset = pr;
        step();
        for (int i = 1; i <= last; i++) begin
            if (abort_at > 0 && i == abort_at + 1) begin
                chk("rst_load", 32'(load_coe), 0);
                chk("rst_coe", 32'(o_init_coe), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_teach", 32'(teach_en), 0);
                reset = 1'b0;
                model_reset();
            end else begin
                kk = (i - 1) / (G + 1);
                le = !pr && ((i - 1) % (G + 1) == 0) && (kk < L);
                ce = le ? mbuf[kk] : '0;
                chk("load_coe", 32'(load_coe), 32'(le));
                chk("o_init_coe", 32'(o_init_coe), 32'(ce));
                chk("preset_coe", 32'(preset_coe), 32'(pr && i == 1));
                chk("busy", 32'(busy), 32'(i <= d_cyc));
                chk("done", 32'(done), 32'(i == d_cyc));
                chk("teach_en", 32'(teach_en), 32'(tr && i > d_cyc));
                chk("cmd_err", 32'(cmd_err),
                    32'(err_at > 0 && i == err_at + 1));
                clr_in();
                if (i == err_at) begin
                    unique case (err_kind)
                        0: cmd_load = 1'b1;
                        1: cmd_preset = 1'b1;
                        default: begin
                            cfg_wr   = 1'b1;
                            cfg_addr = 6'($urandom_range(0, 63));
                            cfg_data = FW'($urandom);
                        end
                    endcase
                end
                if (i == abort_at) reset = 1'b1;
                step();
            end
        end
        clr_in();
    endtask

    initial begin
        reset     = 1'b1;
        teach_req = 1'b1;
        cfg_addr  = '0;
        cfg_data  = '0;
        clr_in();
        cmd_load  = 1'b1;
        model_reset();
        @(negedge clk);
        step();
        step();
        chk("reset_load", 32'(load_coe), 0);
        chk("reset_coe", 32'(o_init_coe), 0);
        chk("reset_preset", 32'(preset_coe), 0);
        chk("reset_teach", 32'(teach_en), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(cmd_err), 0);

        // load from the preset shape, first edge after reset
        reset = 1'b0;
        clr_in();
        run_seq(1, 0, 1, 0, 0, 0);

        // ramp contents, busy-time illegal write must not disturb the buffer
        for (int k = 0; k < L; k++) do_write(k, FW'(k + 1));
        run_seq(1, 0, 1, 30, 2, 0);
        run_seq(1, 0, 0, 0, 0, 0);

        // preset, then preset+load with a rejected load at t+5
        run_seq(0, 1, 1, 0, 0, 0);
        run_seq(1, 1, 0, 5, 0, 0);
        run_seq(0, 1, 1, 10, 1, 0);

        // out-of-range writes are rejected and leave the buffer intact
        do_write(17, FW'(24'h123456));
        do_write(int'($urandom_range(18, 63)), FW'($urandom));

        // randomized contents and request timing
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < L; k++) begin
                do_write(int'($urandom_range(0, L + 4)), FW'($urandom));
            end
            run_seq(1, 0, 1'($urandom), int'($urandom_range(1, 58)),
                    int'($urandom_range(0, 2)), 0);
        end
        run_seq(1, 0, 1, 0, 0, 0);

        // reset in the middle of a load, then confirm the preset shape
        run_seq(1, 0, 1, 0, 0, 20);
        run_seq(1, 0, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pcma_coe_loader.md
PCMA_COE_LOADER -- requirements
Module: pcma_coe_loader

Interface
REQ-001 The block SHALL have parameter COE_WIDTH, default 16, visible coefficient part width.
REQ-002 The block SHALL have parameter INV_COE_WIDTH, default 8, invisible (fractional) coefficient part width; FW = COE_WIDTH+INV_COE_WIDTH.
REQ-003 The block SHALL have parameter EQ_LEN, default 17, equalizer tap count, odd, 3..63.
REQ-004 The block SHALL have parameter GAP, default 2, idle cycles between consecutive load_coe pulses, 0..15.
REQ-005 The block SHALL have parameter SETTLE_LEN, default 8, cycles with teach_en forced low after any load/preset, 1..1023.
REQ-006 The block SHALL have port clk, input, 1 bit, single clock.
REQ-007 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-008 The block SHALL have port cfg_wr, input, 1 bit, coefficient buffer write strobe.
REQ-009 The block SHALL have port cfg_addr, input, 6 bits, tap index to write.
REQ-010 The block SHALL have port cfg_data, input, FW bits, signed coefficient value.
REQ-011 The block SHALL have port cmd_load, input, 1 bit, start streaming the buffer to the equalizer.
REQ-012 The block SHALL have port cmd_preset, input, 1 bit, request an equalizer preset.
REQ-013 The block SHALL have port teach_req, input, 1 bit, host adaptation enable.
REQ-014 The block SHALL have port load_coe, output, 1 bit, one-cycle load pulse per tap.
REQ-015 The block SHALL have port o_init_coe, output, FW bits, coefficient valid while load_coe=1.
REQ-016 The block SHALL have port preset_coe, output, 1 bit, one-cycle preset pulse.
REQ-017 The block SHALL have port teach_en, output, 1 bit, gated adaptation enable.
REQ-018 The block SHALL have port busy, output, 1 bit, sequence in progress.
REQ-019 The block SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-020 The block SHALL have port cmd_err, output, 1 bit, one-cycle pulse on a rejected command or write.

Function
REQ-021 The block SHALL hold an EQ_LEN x FW buffer; cfg_wr in IDLE with cfg_addr<EQ_LEN writes cfg_data at the next edge.
REQ-022 The block SHALL ignore cfg_wr with cfg_addr>=EQ_LEN and pulse cmd_err in the following cycle.
REQ-023 The block SHALL implement FSM states IDLE, PRESET, LOAD, GAP, SETTLE; all outputs SHALL be registered.
REQ-024 In IDLE, cmd_preset sampled at edge t SHALL go to PRESET; preset_coe=1 in cycle t+1 only, then SETTLE.
REQ-025 In IDLE, cmd_load (without cmd_preset) sampled at edge t SHALL go to LOAD with index k=0.
REQ-026 Simultaneous cmd_preset and cmd_load SHALL execute the preset only, with no cmd_err.
REQ-027 In LOAD, pulse k SHALL occur in cycle t+1+k*(GAP+1) with o_init_coe=buf[k], indexes ascending from 0; GAP state SHALL insert GAP idle cycles (skipped when GAP=0).
REQ-028 After pulse EQ_LEN-1 the FSM SHALL enter SETTLE, count SETTLE_LEN cycles, then assert done for one cycle and return to IDLE.
REQ-029 busy SHALL be 1 from the first cycle after the command through the done cycle inclusive, and 0 otherwise.
REQ-030 teach_en SHALL equal teach_req registered and ANDed with (state==IDLE); it SHALL be 0 throughout PRESET/LOAD/GAP/SETTLE.
REQ-031 cmd_load, cmd_preset or cfg_wr while busy SHALL be ignored and SHALL pulse cmd_err in the next cycle; the buffer and sequence SHALL be unaffected.
REQ-032 o_init_coe SHALL be 0 whenever load_coe=0.
REQ-033 The buffer SHALL NOT be modified by a load or preset sequence.

Reset
REQ-034 While reset=1, all outputs SHALL be 0 at the next edge and the FSM SHALL be in IDLE, including when reset occurs mid-sequence (no further pulses, no done).
REQ-035 Reset SHALL initialise the buffer to the preset shape: buf[EQ_LEN/2] = 2**(COE_WIDTH-3)-1, all other taps 0.
REQ-036 The first command SHALL be accepted at the first edge after reset deasserts.

Verification (EQ_LEN=17, GAP=2, SETTLE_LEN=8)
REQ-037 Reset then cmd_load at t -> 17 load_coe pulses at t+1,t+4,...,t+49; o_init_coe = 0 except 8191 at the pulse at t+25; done at t+58; busy for t+1..t+58.
REQ-038 Write buf[k]=k+1 for k=0..16, then cmd_load -> pulses carry 1..17 in order; teach_req=1 throughout -> teach_en=0 for t+1..t+58, 1 from t+59.
REQ-039 cmd_preset at t -> preset_coe at t+1 only; no load_coe; done at t+10.
REQ-040 cmd_load+cmd_preset in the same cycle -> preset only; cmd_load at t+5 -> cmd_err at t+6, no load pulses.
REQ-041 cfg_wr with addr=17 -> cmd_err pulse, buffer unchanged; reset at t+20 of a load -> no pulses after t+20, busy=0 at t+21, buffer back to preset shape.
